// File: rtl/aes_round_key_arbiter.sv
// aes_round_key_arbiter: shared AES round-key store with round-robin enc/dec arbitration.
// Define AES_KEY_ARB_TIMEOUT_EN to revoke a grant held ARB_TIMEOUT cycles against a waiting core.
module aes_round_key_arbiter #(
  parameter int NO_ROWS       = 4,
  parameter int NO_COLS       = 4,
  parameter int NO_ROUND_KEYS = 11,
  parameter int ARB_TIMEOUT   = 32
) (
  input  logic                                aes_clk,
  input  logic                                resetn,
  input  logic                                key_wr_en_i,
  input  logic [3:0]                          key_wr_sel_i,
  input  logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] key_wr_data_i,
  input  logic                                key_clr_i,
  output logic                                key_store_rdy_o,
  input  logic                                enc_key_req_i,
  input  logic [3:0]                          enc_key_sel_i,
  output logic                                enc_key_vld_o,
  output logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] enc_round_key_o,
  input  logic                                dec_key_req_i,
  input  logic [3:0]                          dec_key_sel_i,
  output logic                                dec_key_vld_o,
  output logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] dec_round_key_o,
  output logic                                key_sel_err_o,
  output logic                                arb_timeout_o
);
  typedef logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] key_t;
  typedef enum logic [1:0] {IDLE, LOAD, SERVE} state_t;
  localparam logic ENC = 1'b0;
  localparam logic DEC = 1'b1;
  localparam logic [4:0] NK = 5'(NO_ROUND_KEYS);
  localparam logic [NO_ROUND_KEYS-1:0] ONE = 1;
  state_t state;
  key_t store [NO_ROUND_KEYS];
  logic [NO_ROUND_KEYS-1:0] valid;
  logic owner, last_served;
  logic [3:0] lsel;
  logic enc_elig, dec_elig, grant_dec, sel_bad, wr_ok, own_hold, ent_chg, tmo;
  assign enc_elig  = enc_key_req_i && {1'b0, enc_key_sel_i} < NK;
  assign dec_elig  = dec_key_req_i && {1'b0, dec_key_sel_i} < NK;
  assign grant_dec = dec_elig && (!enc_elig || last_served == ENC);
  assign sel_bad   = (enc_key_req_i && !enc_elig) || (dec_key_req_i && !dec_elig);
  assign wr_ok     = key_wr_en_i && {1'b0, key_wr_sel_i} < NK;
  assign own_hold  = owner ? (dec_key_req_i && dec_key_sel_i == lsel)
                           : (enc_key_req_i && enc_key_sel_i == lsel);
  // any store activity that makes the latched entry stale or absent
  assign ent_chg   = key_clr_i || (wr_ok && key_wr_sel_i == lsel);
`ifdef AES_KEY_ARB_TIMEOUT_EN
  localparam int CW = $clog2(ARB_TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic other_elig;
  assign other_elig = owner ? enc_elig : dec_elig;
  assign tmo = state != IDLE && other_elig && cnt == CW'(ARB_TIMEOUT - 1);
  always_ff @(posedge aes_clk or negedge resetn) begin
    if (!resetn) begin
      cnt           <= '0;
      arb_timeout_o <= 1'b0;
    end else begin
      cnt           <= state == IDLE ? '0 : other_elig ? cnt + 1'b1 : cnt;
      arb_timeout_o <= tmo;
    end
  end
`else
  assign tmo = 1'b0;
  assign arb_timeout_o = 1'b0;
`endif
  always_ff @(posedge aes_clk or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      owner           <= ENC;
      last_served     <= DEC;
      lsel            <= '0;
      valid           <= '0;
      key_store_rdy_o <= 1'b0;
      key_sel_err_o   <= 1'b0;
      enc_key_vld_o   <= 1'b0;
      dec_key_vld_o   <= 1'b0;
      enc_round_key_o <= '0;
      dec_round_key_o <= '0;
      for (int i = 0; i < NO_ROUND_KEYS; i++) store[i] <= '0;
    end else begin
      valid           <= (key_clr_i ? '0 : valid) | (wr_ok ? ONE << key_wr_sel_i : '0);
      if (wr_ok) store[key_wr_sel_i] <= key_wr_data_i;
      key_store_rdy_o <= &valid;
      key_sel_err_o   <= state == IDLE && sel_bad;
      enc_key_vld_o   <= 1'b0;
      dec_key_vld_o   <= 1'b0;
      case (state)
        IDLE: if (enc_elig || dec_elig) begin
          owner <= grant_dec;
          lsel  <= grant_dec ? dec_key_sel_i : enc_key_sel_i;
          state <= LOAD;
        end
        LOAD: if (!own_hold) state <= IDLE;
          else if (tmo) begin
            state       <= IDLE;
            last_served <= owner;
          end else if (valid[lsel] && !ent_chg) begin
            state <= SERVE;
            if (owner) begin
              dec_key_vld_o   <= 1'b1;
              dec_round_key_o <= store[lsel];
            end else begin
              enc_key_vld_o   <= 1'b1;
              enc_round_key_o <= store[lsel];
            end
          end
        SERVE: if (!own_hold || tmo) begin
            state       <= IDLE;
            last_served <= owner;
          end else if (ent_chg || !valid[lsel]) state <= LOAD;
          else if (owner) dec_key_vld_o <= 1'b1;
          else enc_key_vld_o <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
